// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle wide adder/subtractor built on one 5-bit ripple-carry slice.
// The operand pair is latched on acceptance, then one 5-bit slice is processed per cycle,
// LSB slice first. The slice carry-out is registered and feeds the next slice.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   request carries a valid operand pair
//   in_ready   controller can accept a request (IDLE and not in reset)
//   a, b       W-bit operands, W = 5*NSLICE
//   cin        carry-in for add mode, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b computed as a+~b+1
//   out_valid  result available (DONE state)
//   out_ready  consumer accepts the result
//   sum        result modulo 2^W
//   cout       carry out of bit W-1 (sub mode: 1 = no borrow)
//   ovf        two's-complement signed overflow
module rca_seq_ctrl #(
    parameter int unsigned  NSLICE = 4,
    localparam int unsigned W      = 5 * NSLICE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;     // b already inverted for subtract
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic            last_slice;
    int unsigned     base;
    logic [W-1:0]    a_sh, b_sh, slot_mask;
    logic [4:0]      sl_a, sl_b, sl_sum;
    logic            sl_cout;
    logic            rc;

    assign last_slice = (idx_q == IW'(NSLICE - 1));

    // Select the current 5-bit slot with shifts so no out-of-range part select can arise.
    always_comb begin
        base      = 32'd5 * 32'(idx_q);
        a_sh      = a_q >> base;
        b_sh      = b_q >> base;
        slot_mask = W'(5'h1f) << base;
        sl_a      = a_sh[4:0];
        sl_b      = b_sh[4:0];
    end

    // The single 5-bit ripple-carry slice.
    always_comb begin
        rc     = carry_q;
        sl_sum = '0;
        for (int i = 0; i < 5; i++) begin
            sl_sum[i] = sl_a[i] ^ sl_b[i] ^ rc;
            rc        = (sl_a[i] & sl_b[i]) | (rc & (sl_a[i] ^ sl_b[i]));
        end
        sl_cout = rc;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = (sum_q & ~slot_mask) | ((W'(sl_sum) << base) & slot_mask);
                carry_d = sl_cout;
                if (last_slice) begin
                    cout_d  = sl_cout;
                    // Overflow: operand signs agree but the result sign differs.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sl_sum[4] != a_q[W-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl (NSLICE=4, W=20). Directed cases use hand-derived constants;
// randomized cases use a whole-word arithmetic reference model.
module tb_rca_seq_ctrl;

    localparam int NSLICE = 4;
    localparam int W      = 5 * NSLICE;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int vectors    = 0;
    int miscompares = 0;

    rca_seq_ctrl #(.NSLICE(NSLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Whole-word reference: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        longint ua, ub, tot, sa, sb, r, lim;
        logic [W-1:0] nb;
        logic         mo;
        nb  = ~mb;
        lim = longint'(1) << (W - 1);
        ua  = longint'(ma);
        ub  = msub ? longint'(nb) : longint'(mb);
        tot = ua + ub + (msub ? longint'(1) : longint'(mcin));
        sa  = ma[W-1] ? ua - 2 * lim : ua;
        sb  = mb[W-1] ? longint'(mb) - 2 * lim : longint'(mb);
        r   = msub ? sa - sb : sa + sb + longint'(mcin);
        mo  = (r > lim - 1) || (r < -lim);
        return {mo, tot[W], tot[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '1;
            1: v = {1'b0, {(W-1){1'b1}}};
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = '0;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Runs one full transaction; reports what it saw, the caller judges it.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input int hold, output logic [W-1:0] gs,
                         output logic gc, output logic go, output int lat,
                         output logic busy_ok, output logic done);
        done    = 1'b0;
        busy_ok = 1'b1;
        lat     = 0;
        gs      = '0;
        gc      = 1'b0;
        go      = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) return;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        while (!out_valid && lat < 50) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) return;
        gs = sum; gc = cout; go = ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (in_ready || !out_valid || sum !== gs || cout !== gc || ovf !== go)
                busy_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid || !in_ready) busy_ok = 1'b0;
        done = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        vectors++;
        if ({out_valid, ovf, cout, sum} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b o=%b c=%b s=%h exp all zero",
                     out_valid, ovf, cout, sum);
        end
        rst = 1'b0; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[8] = '{20'h00001, 20'hFFFFF, 20'hFFFFF, 20'h00005,
                                20'h00007, 20'h7FFFF, 20'h80000, 20'h00010};
        logic [W-1:0] vb[8] = '{20'h00002, 20'h00001, 20'h00000, 20'h00007,
                                20'h00005, 20'h00001, 20'h00001, 20'h00020};
        logic         vc[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        logic         vs[8] = '{0, 0, 0, 1, 1, 0, 1, 0};
        logic [W-1:0] es[8] = '{20'h00003, 20'h00000, 20'h00000, 20'hFFFFE,
                                20'h00002, 20'h80000, 20'h7FFFF, 20'h00030};
        logic         ec[8] = '{0, 1, 1, 0, 1, 0, 1, 0};
        logic         eo[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
        logic [W-1:0] gs;
        logic gc, go, busy_ok, done;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], vc[i], vs[i], 0, gs, gc, go, lat, busy_ok, done);
            vectors++;
            if (done !== 1'b1) begin
                miscompares++; $display("FAIL dir%0d_timeout got done=%b exp 1", i, done);
                continue;
            end
            vectors++;
            if (lat != NSLICE) begin
                miscompares++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, NSLICE);
            end
            vectors++;
            if ({go, gc, gs} !== {eo[i], ec[i], es[i]}) begin
                miscompares++;
                $display("FAIL dir%0d_result got s=%h c=%b o=%b exp s=%h c=%b o=%b",
                         i, gs, gc, go, es[i], ec[i], eo[i]);
            end
            vectors++;
            if (busy_ok !== 1'b1) begin
                miscompares++; $display("FAIL dir%0d_handshake got %b exp 1", i, busy_ok);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb, gs;
        logic tc, ts, gc, go, busy_ok, done;
        logic [W+1:0] e;
        int lat;
        for (int i = 0; i < 60; i++) begin
            ta = pick_operand(); tb = pick_operand();
            tc = 1'($urandom); ts = 1'($urandom);
            e  = model(ta, tb, tc, ts);
            do_op(ta, tb, tc, ts, int'($urandom_range(0, 2)), gs, gc, go, lat, busy_ok, done);
            vectors++;
            if (done !== 1'b1 || lat != NSLICE || busy_ok !== 1'b1 || {go, gc, gs} !== e) begin
                miscompares++;
                $display("FAIL rand%0d got done=%b lat=%0d hs=%b s=%h c=%b o=%b exp s=%h c=%b o=%b",
                         i, done, lat, busy_ok, gs, gc, go, e[W-1:0], e[W], e[W+1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] gs, na, nb;
        logic gc, go, busy_ok, done;
        logic [W+1:0] e1, e2;
        int lat;
        e1 = model(20'h12345, 20'h0ABCD, 1'b1, 1'b0);
        a = 20'h12345; b = 20'h0ABCD; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        na = 20'h54321; nb = 20'h11111;
        e2 = model(na, nb, 1'b0, 1'b1);
        a = na; b = nb; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== e1) begin
                miscompares++;
                $display("FAIL bp_hold%0d got v=%b r=%b s=%h exp v=1 r=0 s=%h",
                         i, out_valid, in_ready, sum, e1[W-1:0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_pending_taken got ready=%b exp 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        gs = sum; gc = cout; go = ovf;
        vectors++;
        if (lat != NSLICE || {go, gc, gs} !== e2) begin
            miscompares++;
            $display("FAIL bp_pending_result got lat=%0d s=%h c=%b o=%b exp lat=%0d s=%h c=%b o=%b",
                     lat, gs, gc, go, NSLICE, e2[W-1:0], e2[W], e2[W+1]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        busy_ok = 1'b1; done = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] gs;
        logic gc, go, busy_ok, done, seen;
        int lat;
        a = 20'hFFFFF; b = 20'h00001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_ready got %b exp 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_ready_after got %b exp 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < NSLICE + 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_no_result got out_valid seen=%b exp 0", seen);
        end
        do_op(20'h00010, 20'h00020, 1'b0, 1'b0, 0, gs, gc, go, lat, busy_ok, done);
        vectors++;
        if (done !== 1'b1 || {go, gc, gs} !== {1'b0, 1'b0, 20'h00030}) begin
            miscompares++;
            $display("FAIL rst_mid_next_op got done=%b s=%h c=%b o=%b exp s=00030 c=0 o=0",
                     done, gs, gc, go);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] expq[$];
        logic [W+1:0] e;
        int last_acc;
        last_acc = -1;
        out_ready = 1'b1; in_valid = 1'b1;
        a = pick_operand(); b = pick_operand(); cin = 1'($urandom); sub = 1'($urandom);
        for (int c = 0; c < 40 + NSLICE + 3; c++) begin
            if (c == 40) in_valid = 1'b0;
            if (out_valid) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++; $display("FAIL b2b_unexpected got result s=%h exp none", sum);
                end else begin
                    e = expq.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        miscompares++;
                        $display("FAIL b2b_result got s=%h c=%b o=%b exp s=%h c=%b o=%b",
                                 sum, cout, ovf, e[W-1:0], e[W], e[W+1]);
                    end
                end
            end
            if (in_ready && in_valid) begin
                expq.push_back(model(a, b, cin, sub));
                if (last_acc >= 0) begin
                    vectors++;
                    if (c - last_acc != NSLICE + 2) begin
                        miscompares++;
                        $display("FAIL b2b_gap got %0d exp %0d", c - last_acc, NSLICE + 2);
                    end
                end
                last_acc = c;
            end
            @(posedge clk); #1;
            a = pick_operand(); b = pick_operand(); cin = 1'($urandom); sub = 1'($urandom);
        end
        out_ready = 1'b0;
        vectors++;
        if (expq.size() != 0 || last_acc < 0) begin
            miscompares++;
            $display("FAIL b2b_drain got pending=%0d last=%0d exp pending=0", expq.size(), last_acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a W = 5*NSLICE bit add or subtract by feeding one 5-bit ripple-carry adder slice once per cycle, least significant slice first.
- The carry-out of each slice is registered and becomes the carry-in of the next slice.
- Sits between a requester using valid/ready on the input side and a consumer using valid/ready on the output side.
- Lets wide arithmetic reuse the team's 5-bit adder datapath instead of a wide combinational adder.

Parameters:
NSLICE, 4, number of 5-bit slices; operand width W = 5*NSLICE (default 20); legal range 1..16

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request carries a valid operand pair
in_ready  output  1  controller can accept a request
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in for add mode; ignored when sub=1
sub  input  1  0 = A+B+cin, 1 = A-B (computed as A + ~B + 1)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  W  result, modulo 2^W
cout  output  1  carry out of bit W-1; in sub mode, 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Single internal instance of a 5-bit ripple-carry adder slice; no other adders in the block.
- States: IDLE, RUN, DONE. State register and slice index idx (width clog2(NSLICE), minimum 1 bit).
- Reset (rst=1 at an edge):
  - state=IDLE, idx=0; carry, operand, sum, cout and ovf registers cleared to 0.
  - out_valid=0. in_ready is forced to 0 while rst=1.
  - Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and no out_valid is produced.
- in_ready = (state==IDLE) && !rst. in_ready is 1 in the first cycle after reset deasserts.
- IDLE:
  - On in_valid && in_ready: latch a, b_eff (= sub ? ~b : b) and carry_reg (= sub ? 1 : cin); set idx=0; go to RUN.
  - Input changes after acceptance have no effect.
- RUN, each cycle:
  - Slice inputs: a[5*idx +: 5], b_eff[5*idx +: 5], carry_reg.
  - Slice sum bits are written to sum_reg[5*idx +: 5]; slice carry-out is written to carry_reg.
  - If idx==NSLICE-1: cout <= slice carry-out; ovf <= (a[W-1]==b_eff[W-1]) && (slice sum MSB != a[W-1]); go to DONE.
  - Otherwise idx <= idx+1.
- Latency:
  - Acceptance happens at rising edge E0. out_valid is high after edge E0+NSLICE, i.e. exactly NSLICE cycles later.
  - Throughput: at most one operation per NSLICE+2 cycles (in_ready is low in RUN and DONE).
- DONE:
  - out_valid=1; sum, cout and ovf are stable and held.
  - On out_ready=1: go to IDLE; out_valid drops at the next edge.
  - out_ready=0 holds DONE indefinitely (backpressure); in_valid is ignored while in DONE.
- out_valid = (state==DONE). sum, cout and ovf retain their last values in IDLE.
- sum/cout/ovf are only meaningful while out_valid=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- NSLICE=1 degenerates to a single RUN cycle; behaviour is otherwise identical.

Test Plan:
1. Basic add (NSLICE=4): a=0x00001, b=0x00002, cin=0, sub=0 -> sum=0x00003, cout=0, ovf=0; out_valid rises exactly 4 cycles after acceptance; in_ready=0 until the result handshake completes.
2. Full ripple across all slices: a=0xFFFFF, b=0x00001, cin=0 -> sum=0x00000, cout=1, ovf=0. Also a=0xFFFFF, b=0x00000, cin=1 -> sum=0x00000, cout=1.
3. Subtract with borrow: a=0x00005, b=0x00007, sub=1, cin=1 (ignored) -> sum=0xFFFFE, cout=0, ovf=0. Then a=0x00007, b=0x00005, sub=1 -> sum=0x00002, cout=1.
4. Signed overflow: a=0x7FFFF, b=0x00001, sub=0 -> sum=0x80000, ovf=1, cout=0. Also a=0x80000, b=0x00001, sub=1 -> sum=0x7FFFF, ovf=1.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> sum, cout and out_valid held; in_ready=0; the new request is not taken. Raise out_ready -> IDLE next cycle, then the pending request is accepted.
6. Reset mid-operation: assert rst for 1 cycle after 2 RUN slices of a=0xFFFFF, b=0x00001 -> out_valid never rises for that operation; in_ready=1 the cycle after rst drops. The next op a=0x00010, b=0x00020 returns 0x00030 with no stale carry.
